// File: rtl/data_c_pipe_pack_if.sv
// Stream bundle for data_c_pipe_pack: narrow beat input side and packed wide word output side.
// master drives the beat stream and out_ready; slave is the packer itself.
interface data_c_pipe_pack_if #(
   parameter int unsigned DSIZE = 32,
   parameter int unsigned NUM   = 4
);
   logic                 in_valid;
   logic                 in_ready;
   logic [DSIZE-1:0]     in_data;
   logic                 in_last;
   logic                 out_valid;
   logic                 out_ready;
   logic [NUM*DSIZE-1:0] out_data;
   logic [NUM-1:0]       out_keep;
   logic                 out_last;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_keep, out_last
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_keep, out_last
   );
endinterface

// File: rtl/data_c_pipe_pack.sv
// Packs NUM narrow beats into one registered wide word; in_last flushes a partial word with a keep mask.
// Build option: define DATA_C_PIPE_PACK_MSB_FIRST_EN to place the first beat (and keep bit) in the MSB lane.
module data_c_pipe_pack #(
   parameter int unsigned DSIZE = 32,
   parameter int unsigned NUM   = 4
) (
   input logic               clock,
   input logic               rst,
   data_c_pipe_pack_if.slave bus
);
   localparam int unsigned   CW        = (NUM > 1) ? $clog2(NUM) : 1;
   localparam logic [CW-1:0] LAST_LANE = CW'(NUM - 1);

   logic [CW-1:0]        cnt;
   logic [NUM*DSIZE-1:0] acc;
   logic [NUM-1:0]       keep_acc;
   logic [NUM*DSIZE-1:0] word;
   logic [NUM-1:0]       keep;
   logic                 out_valid_q;
   logic [NUM*DSIZE-1:0] out_data_q;
   logic [NUM-1:0]       out_keep_q;
   logic                 out_last_q;
   logic                 in_ready;
   logic                 accept;
   logic                 complete;

   assign in_ready = !out_valid_q || bus.out_ready;
   assign accept   = bus.in_valid && in_ready;
   assign complete = (cnt == LAST_LANE) || bus.in_last;

   // Accumulator with the current beat merged into lane cnt; loaded as a whole on completion.
   always_comb begin
      word = acc;
      keep = keep_acc;
      for (int unsigned k = 0; k < NUM; k++) begin
         if (cnt == CW'(k)) begin
`ifdef DATA_C_PIPE_PACK_MSB_FIRST_EN
            word[(NUM-1-k)*DSIZE +: DSIZE] = bus.in_data;
            keep[NUM-1-k]                  = 1'b1;
`else
            word[k*DSIZE +: DSIZE] = bus.in_data;
            keep[k]                = 1'b1;
`endif
         end
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         cnt         <= '0;
         acc         <= '0;
         keep_acc    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         if (out_valid_q && bus.out_ready)
            out_valid_q <= 1'b0;
         // A completing beat overrides the handshake clear so back-to-back words have no bubble.
         if (accept) begin
            if (complete) begin
               out_valid_q <= 1'b1;
               out_data_q  <= word;
               out_keep_q  <= keep;
               out_last_q  <= bus.in_last;
               cnt         <= '0;
               acc         <= '0;
               keep_acc    <= '0;
            end else begin
               acc      <= word;
               keep_acc <= keep;
               cnt      <= cnt + 1'b1;
            end
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_keep  = out_keep_q;
   assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_data_c_pipe_pack.sv
// Bench for data_c_pipe_pack (DSIZE=8, NUM=4, plus a NUM=1 instance): directed steps and a random
// phase, checked against a beat-list/word-queue reference model.
module tb_data_c_pipe_pack;
   localparam int unsigned D = 8;
   localparam int unsigned N = 4;

   typedef struct {
      logic [N*D-1:0] d;
      logic [N-1:0]   k;
      logic           l;
   } word_t;

   logic clock = 1'b0;
   logic rst;
   int unsigned checks = 0;
   int unsigned passes = 0;
   int unsigned words_seen = 0;

   logic [D-1:0] pend[$];
   word_t        exp_q[$];

   data_c_pipe_pack_if #(.DSIZE(D), .NUM(N)) bus ();
   data_c_pipe_pack_if #(.DSIZE(D), .NUM(1)) bus1 ();

   data_c_pipe_pack #(.DSIZE(D), .NUM(N)) dut (.clock(clock), .rst(rst), .bus(bus));
   data_c_pipe_pack #(.DSIZE(D), .NUM(1)) dut1 (.clock(clock), .rst(rst), .bus(bus1));

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic word_t build_word(input logic last);
      word_t w;
      int unsigned lane;
      w.d = '0;
      w.k = '0;
      w.l = last;
      for (int i = 0; i < pend.size(); i++) begin
`ifdef DATA_C_PIPE_PACK_MSB_FIRST_EN
         lane = N - 1 - i;
`else
         lane = i;
`endif
         w.d[lane*D +: D] = pend[i];
         w.k[lane]        = 1'b1;
      end
      return w;
   endfunction

   // One clock: check handshake outputs against the model, update the model, advance past the edge.
   task automatic tick();
      logic  exp_valid;
      logic  exp_ready;
      word_t w;
      #1;
      exp_valid = (exp_q.size() != 0);
      exp_ready = !exp_valid || bus.out_ready;
      chk("in_ready", bus.in_ready, exp_ready);
      chk("out_valid", bus.out_valid, exp_valid);
      if (exp_valid) begin
         chk("out_data_hold", bus.out_data, exp_q[0].d);
         chk("out_keep_hold", bus.out_keep, exp_q[0].k);
         chk("out_last_hold", bus.out_last, exp_q[0].l);
      end
      if (!rst) begin
         if (exp_valid && bus.out_ready) begin
            void'(exp_q.pop_front());
            words_seen++;
         end
         if (bus.in_valid && exp_ready) begin
            pend.push_back(bus.in_data);
            if (pend.size() == N || bus.in_last) begin
               w = build_word(bus.in_last);
               exp_q.push_back(w);
               pend.delete();
            end
         end
      end
      @(posedge clock);
      if (rst) begin
         pend.delete();
         exp_q.delete();
      end
      #1;
   endtask

   task automatic beat(input logic [D-1:0] d, input logic last);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      tick();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
      bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_last = 1'b0; bus1.out_ready = 1'b1;
      @(posedge clock); #1;
      @(posedge clock); #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_keep", bus.out_keep, 0);
      chk("rst_out_last", bus.out_last, 0);
      rst = 1'b0;

      // 1: four bytes back-to-back
      beat(8'h01, 0); beat(8'h02, 0); beat(8'h03, 0); beat(8'h04, 0);
`ifdef DATA_C_PIPE_PACK_MSB_FIRST_EN
      chk("t1_data", bus.out_data, 32'h01020304);
`else
      chk("t1_data", bus.out_data, 32'h04030201);
`endif
      chk("t1_keep", bus.out_keep, 4'hF);
      chk("t1_last", bus.out_last, 0);
      tick();

      // 2: partial word flushed by in_last, next word restarts at lane 0
      beat(8'hAA, 0); beat(8'hBB, 1);
`ifdef DATA_C_PIPE_PACK_MSB_FIRST_EN
      chk("t2_data", bus.out_data, 32'hAABB0000);
      chk("t2_keep", bus.out_keep, 4'hC);
`else
      chk("t2_data", bus.out_data, 32'h0000BBAA);
      chk("t2_keep", bus.out_keep, 4'h3);
`endif
      chk("t2_last", bus.out_last, 1);
      tick();
      beat(8'hC1, 1);
`ifdef DATA_C_PIPE_PACK_MSB_FIRST_EN
      chk("t2_lane0_keep", bus.out_keep, 4'h8);
`else
      chk("t2_lane0_keep", bus.out_keep, 4'h1);
`endif
      tick();

      // 3: hold a word with out_ready=0 while upstream keeps offering beats
      beat(8'h10, 0); beat(8'h20, 0); beat(8'h30, 0);
      bus.out_ready = 1'b0;
      beat(8'h40, 0);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.in_data = 8'h50 + 8'(i);
         tick();
      end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.in_data = 8'h60 + 8'(i);
         tick();
      end
      bus.in_valid = 1'b0;
      tick();
      tick();

      // 4: 16 continuous beats, no bubbles
      words_seen = 0;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         bus.in_data = 8'(i * 3 + 1);
         tick();
      end
      bus.in_valid = 1'b0;
      tick();
      chk("t4_words", words_seen, 4);

      // 5: reset mid-word discards the partial accumulation
      beat(8'hE1, 0); beat(8'hE2, 0);
      rst = 1'b1;
      tick();
      chk("t5_rst_valid", bus.out_valid, 0);
      chk("t5_rst_data", bus.out_data, 0);
      chk("t5_rst_keep", bus.out_keep, 0);
      rst = 1'b0;
      beat(8'h11, 0); beat(8'h22, 0); beat(8'h33, 0); beat(8'h44, 0);
`ifdef DATA_C_PIPE_PACK_MSB_FIRST_EN
      chk("t5_data", bus.out_data, 32'h11223344);
`else
      chk("t5_data", bus.out_data, 32'h44332211);
`endif
      tick();

      // Random traffic with random backpressure and flushes
      for (int i = 0; i < 400; i++) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_data   = 8'($urandom);
         bus.in_last   = ($urandom_range(0, 5) == 0);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      bus.in_valid = 1'b0;
      bus.in_last = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      tick();

      // NUM=1 instance: every beat is a full word
      bus1.in_valid = 1'b1;
      bus1.in_data  = 8'h5A;
      @(posedge clock); #1;
      bus1.in_valid = 1'b0;
      chk("n1_valid", bus1.out_valid, 1);
      chk("n1_data", bus1.out_data, 8'h5A);
      chk("n1_keep", bus1.out_keep, 1);
      chk("n1_last", bus1.out_last, 0);
      @(posedge clock); #1;
      chk("n1_drain", bus1.out_valid, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
